// File: rtl/button_io.sv
// Debounced 3-button input block with sticky press flags, 8-bit press counters and a level IRQ.
// Reads return one cycle after the select edge; single-cycle bus with no backpressure.
module button_io #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SEL,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [4:0]  WMASK,
  input  logic [2:0]  BUTTONS,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFS_LEVEL = 3'b100;
  localparam logic [2:0] OFS_PRESS = 3'b101;
  localparam logic [2:0] OFS_COUNT = 3'b110;
  localparam logic [2:0] OFS_CTRL  = 3'b111;

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       db_nxt;
  logic [2:0][7:0]  db_cnt;
  logic [2:0][7:0]  db_cnt_nxt;
  logic [2:0]       rise;
  logic [2:0]       press;
  logic [2:0][7:0]  cnt;
  logic             ien;
  logic             wr_en;
  logic             wr_press;
  logic             wr_count;
  logic             wr_ctrl;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign unused_bits = ^{ADDR[31:5], ADDR[1:0], WDATA[31:24], WMASK[4:1]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1  <= BUTTONS;
      sync2  <= sync1;
      db     <= db_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // rise flags the edge on which db goes 0->1, so press/cnt update together with db
  always_comb begin
    db_nxt     = db;
    db_cnt_nxt = db_cnt;
    rise       = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2[i] == db[i]) begin
        db_cnt_nxt[i] = '0;
      end else if (db_cnt[i] == CNT_LAST) begin
        db_nxt[i]     = sync2[i];
        db_cnt_nxt[i] = '0;
        rise[i]       = sync2[i];
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + 8'd1;
      end
    end
  end

  assign wr_en    = SEL & WMASK[0];
  assign wr_press = wr_en & (ADDR[4:2] == OFS_PRESS);
  assign wr_count = wr_en & (ADDR[4:2] == OFS_COUNT);
  assign wr_ctrl  = wr_en & (ADDR[4:2] == OFS_CTRL);

  always_comb begin
    rd_val = '0;
    case (ADDR[4:2])
      OFS_LEVEL: rd_val = {29'b0, db};
      OFS_PRESS: rd_val = {29'b0, press};
      OFS_COUNT: rd_val = {8'b0, cnt[2], cnt[1], cnt[0]};
      OFS_CTRL:  rd_val = {31'b0, ien};
      default:   rd_val = '0;
    endcase
  end

  // Edge set beats a same-cycle W1C; a COUNT write beats a same-cycle increment
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      press <= '0;
      cnt   <= '0;
      ien   <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_press) begin
        press <= (press & ~WDATA[2:0]) | rise;
      end else begin
        press <= press | rise;
      end
      if (wr_count) begin
        cnt <= WDATA[23:0];
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (rise[i]) begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end
      end
      if (wr_ctrl) begin
        ien <= WDATA[0];
      end
      rdata <= SEL ? rd_val : '0;
      irq   <= ien & (|press);
    end
  end

endmodule

// File: tb/tb_button_io.sv
// Directed bench for button_io: reads push expected data into a scoreboard, a negedge monitor checks rdata.
module tb_button_io;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        SEL = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [4:0]  WMASK = '0;
  logic [2:0]  BUTTONS = '0;
  logic [31:0] rdata;
  logic        irq;

  logic        rd_issue = 1'b0;
  logic        rd_issue_q = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;
  int          n_cmp = 0;
  int          n_err = 0;

  button_io #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .SEL(SEL),
    .ADDR(ADDR),
    .WDATA(WDATA),
    .WMASK(WMASK),
    .BUTTONS(BUTTONS),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) rd_issue_q <= rd_issue;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read cycle presents rdata one edge later
  always @(negedge CLK) begin
    if (rd_issue_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, rdata, mon_exp);
      end
    end
  end

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wm, input logic rd);
    @(negedge CLK);
    SEL      = sel;
    ADDR     = addr;
    WDATA    = wd;
    WMASK    = wm;
    rd_issue = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 32'h0, 5'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, addr, data, 5'b00001, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    drive(1'b1, addr, 32'h0, 5'b0, 1'b1);
  endtask

  task automatic set_btn(input logic [2:0] v);
    idle(1);
    BUTTONS = v;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    idle(1);
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RESET_N = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    idle(3);
    @(negedge CLK) RESET_N = 1'b1;

    // Reset state of the whole register map
    rd(32'h10, 32'h0, "rst_level");
    rd(32'h14, 32'h0, "rst_press");
    rd(32'h18, 32'h0, "rst_count");
    rd(32'h1C, 32'h0, "rst_ctrl");
    rd(32'h00, 32'h0, "rst_unmapped");
    idle(1);

    // Scenario 1: debounce latency, press flag and counter
    set_btn(3'b001);
    idle(4);
    rd(32'h10, 32'h0, "s1_level_cycle6_pre");
    rd(32'h10, 32'h1, "s1_level");
    rd(32'h14, 32'h1, "s1_press");
    rd(32'h18, 32'h1, "s1_count");
    chk_irq(1'b0, "s1_irq_disabled");
    set_btn(3'b000);
    idle(8);
    rd(32'h10, 32'h0, "s1_level_released");
    rd(32'h14, 32'h1, "s1_press_sticky");
    rd(32'h18, 32'h1, "s1_count_no_fall_inc");
    wr(32'h14, 32'h1);
    rd(32'h14, 32'h0, "s1_press_w1c");

    // Scenario 2: 3-cycle glitch on button 1
    set_btn(3'b010);
    idle(2);
    set_btn(3'b000);
    idle(10);
    rd(32'h10, 32'h0, "s2_level");
    rd(32'h14, 32'h0, "s2_press");
    rd(32'h18, 32'h1, "s2_count");

    // Scenario 3: interrupt path
    wr(32'h1C, 32'h1);
    rd(32'h1C, 32'h1, "s3_ctrl");
    chk_irq(1'b0, "s3_irq_idle");
    set_btn(3'b100);
    idle(5);
    chk_irq(1'b0, "s3_irq_same_cycle_as_press");
    chk_irq(1'b1, "s3_irq_rise");
    wr(32'h14, 32'h4);
    chk_irq(1'b1, "s3_irq_hold_one_cycle");
    chk_irq(1'b0, "s3_irq_fall");
    rd(32'h14, 32'h0, "s3_press_cleared");
    wr(32'h1C, 32'h0);
    set_btn(3'b000);
    idle(8);
    rd(32'h18, 32'h0001_0001, "s3_count");

    // Scenario 4: collisions with a button-0 edge
    set_btn(3'b001);
    idle(4);
    wr(32'h14, 32'h1);
    rd(32'h14, 32'h1, "s4_w1c_set_wins");
    rd(32'h18, 32'h0001_0002, "s4_count_inc");
    set_btn(3'b000);
    idle(8);
    wr(32'h14, 32'h1);
    rd(32'h14, 32'h0, "s4_press_cleared");
    set_btn(3'b001);
    idle(4);
    wr(32'h18, 32'h00FF_00FE);
    rd(32'h18, 32'h00FF_00FE, "s4_count_write_wins");
    set_btn(3'b000);
    idle(8);

    // Scenario 5: counter wrap and bus gating
    wr(32'h18, 32'h0000_00FF);
    set_btn(3'b001);
    idle(6);
    rd(32'h18, 32'h0, "s5_wrap");
    set_btn(3'b000);
    idle(8);
    drive(1'b0, 32'h18, 32'h0012_3456, 5'b00001, 1'b0);
    drive(1'b1, 32'h18, 32'h0065_4321, 5'b11110, 1'b0);
    drive(1'b0, 32'h1C, 32'h1, 5'b00001, 1'b0);
    drive(1'b1, 32'h14, 32'h7, 5'b00000, 1'b0);
    rd(32'h18, 32'h0, "s5_gate_count");
    rd(32'h1C, 32'h0, "s5_gate_ctrl");
    rd(32'h14, 32'h1, "s5_gate_press");
    exp_q.push_back(32'h0);
    name_q.push_back("s5_sel0_read");
    drive(1'b0, 32'h14, 32'h0, 5'b0, 1'b1);
    wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h04, 32'h0, "s5_unmapped");
    rd(32'h18, 32'h0, "s5_count_after_unmapped");

    // Scenario 6: asynchronous reset mid-debounce
    set_btn(3'b110);
    idle(6);
    wr(32'h18, 32'h0003_0201);
    wr(32'h1C, 32'h1);
    idle(1);
    chk_irq(1'b1, "s6_irq_pre");
    set_btn(3'b111);
    idle(1);
    rd(32'h18, 32'h0003_0201, "s6_count_pre");
    rd(32'h14, 32'h7, "s6_press_pre");
    idle(1);
    #2 RESET_N = 1'b0;
    #1;
    check("s6_rst_rdata", rdata, 32'h0);
    check("s6_rst_irq", {31'b0, irq}, 32'h0);
    check("s6_rst_press", {29'b0, dut.press}, 32'h0);
    check("s6_rst_cnt", {8'b0, dut.cnt}, 32'h0);
    check("s6_rst_ien", {31'b0, dut.ien}, 32'h0);
    check("s6_rst_db", {29'b0, dut.db}, 32'h0);
    check("s6_rst_db_cnt", {8'b0, dut.db_cnt}, 32'h0);
    check("s6_rst_sync", {26'b0, dut.sync1, dut.sync2}, 32'h0);
    idle(2);
    @(negedge CLK) RESET_N = 1'b1;
    idle(4);
    rd(32'h10, 32'h0, "s6_level_pre_latch");
    rd(32'h10, 32'h7, "s6_level_relatch");
    rd(32'h14, 32'h7, "s6_press_after_rst");
    rd(32'h18, 32'h0001_0101, "s6_count_after_rst");
    idle(10);
    rd(32'h18, 32'h0001_0101, "s6_count_once");
    chk_irq(1'b0, "s6_irq_after_rst");

    idle(3);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_io.md
BUTTON_IO -- requirements
Module: button_io

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized cycles required to accept a new button level; legal range 2..255.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port SEL  input  1  bus select; high when the CPU address falls in the IO window.
REQ-005 SHALL have port ADDR  input  32  byte address from the CPU; only ADDR[4:2] is decoded.
REQ-006 SHALL have port WDATA  input  32  write data.
REQ-007 SHALL have port WMASK  input  5  write mask; a write occurs only when WMASK[0]=1, and the whole word is written.
REQ-008 SHALL have port BUTTONS  input  3  raw asynchronous button levels, active high.
REQ-009 SHALL have port rdata  output  32  registered read data.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 Register map, decoded on ADDR[4:2], SHALL be as follows.
- 0x10 LEVEL (RO): {29'b0, db[2:0]}, the debounced levels.
- 0x14 PRESS (R/W1C): {29'b0, press[2:0]}, sticky rising-edge flags.
- 0x18 COUNT (R/W): {8'b0, cnt2, cnt1, cnt0}, 8-bit press counters.
- 0x1C CTRL (R/W): {31'b0, ien}, interrupt enable.
- All other offsets: read 0, writes ignored.
REQ-012 Each BUTTONS bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Debounce SHALL use one counter per button, as follows.
- If sync==db, the counter clears.
- Otherwise the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 while sync!=db, db takes sync and the counter clears.
REQ-014 A single-cycle glitch shorter than DEBOUNCE_CYCLES SHALL leave db unchanged.
REQ-015 Latency from a stable BUTTONS change to db update SHALL be 2+DEBOUNCE_CYCLES cycles.
REQ-016 A 0->1 transition of db[i] SHALL set press[i] and increment cnt[i] in the same cycle; the counter wraps 255->0.
REQ-017 A 1->0 transition of db[i] SHALL NOT change press or cnt.
REQ-018 Reads SHALL have 1-cycle latency.
- On a rising edge with SEL=1, rdata loads the addressed register value as it stood before that edge.
- On a rising edge with SEL=0, rdata loads 0.
REQ-019 A write SHALL occur on a rising edge with SEL=1 and WMASK[0]=1, and SHALL take effect at that edge.
REQ-020 A PRESS write SHALL clear press[i] for each WDATA[i]=1, i=0..2.
- If a new edge for button i occurs in the same cycle, press[i] ends at 1 (set wins).
REQ-021 A COUNT write SHALL load cnt0=WDATA[7:0], cnt1=WDATA[15:8], cnt2=WDATA[23:16].
- If an increment coincides with the write, the written value wins and the increment is lost.
REQ-022 A CTRL write SHALL load ien=WDATA[0].
REQ-023 irq SHALL be registered: irq <= ien & |press.
- irq asserts one cycle after the press flag or ien becomes set.
- irq deasserts one cycle after the condition clears.
REQ-024 A read of PRESS or COUNT SHALL have no side effects.
REQ-025 Operation with WMASK[0]=0 or SEL=0 SHALL never modify any register.

Reset
REQ-026 While RESET_N=0, the following SHALL be 0 immediately, independent of CLK:
- rdata, irq, ien, press, cnt0..2, db, synchronizer flops and debounce counters.
REQ-027 Reset asserted mid-debounce or mid-access SHALL discard the pending level and the access.
REQ-028 After RESET_N rises, a button already held high SHALL produce db=1 after 2+DEBOUNCE_CYCLES cycles, setting press and incrementing cnt exactly once.

Verification
REQ-029 Scenario 1, debounce: DEBOUNCE_CYCLES=4, BUTTONS[0] 0->1 held.
- db[0]=1 at cycle 6.
- press[0]=1, cnt0=1, rdata at 0x10 = 0x1 on the read cycle.
REQ-030 Scenario 2, glitch: pulse BUTTONS[1] high for 3 cycles, then low.
- LEVEL stays 0, PRESS stays 0, cnt1 stays 0.
REQ-031 Scenario 3, interrupt path: write CTRL=1, then press button 2.
- irq rises 1 cycle after press[2].
- Write PRESS=0x4; irq falls 1 cycle later and PRESS reads 0.
REQ-032 Scenario 4, collisions:
- W1C of PRESS on the exact cycle of a new button-0 edge -> PRESS reads 0x1.
- COUNT write 0x00FF00FE coincident with a button-0 edge -> cnt0=0xFE.
REQ-033 Scenario 5, wrap and bus gating:
- Preload COUNT=0x000000FF, then press button 0 -> cnt0=0x00.
- A write with SEL=0 or WMASK=0 changes nothing.
- A read with SEL=0 returns rdata=0.
REQ-034 Scenario 6, reset: assert RESET_N=0 asynchronously mid-debounce with press=0x7, cnt=0x030201, irq=1.
- All outputs and registers read 0 immediately.
